wb_arb_rr2: RTL and testbench
=============================

WB_ARB_RR2 -- requirements
Module: wb_arb_rr2

Interface
REQ-001 SHALL have parameter C_TIMEOUT, default 255, meaning slave-response timeout in wb_clk_i cycles (legal 2..255, 8-bit counter).
REQ-002 SHALL have port wb_clk_i  input  1  single clock for all logic.
REQ-003 SHALL have port wb_rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports m0_cyc_i / m1_cyc_i  input  1  master bus-cycle request.
REQ-005 SHALL have ports m0_stb_i / m1_stb_i  input  1  master strobe.
REQ-006 SHALL have ports m0_we_i / m1_we_i  input  1  master write enable.
REQ-007 SHALL have ports m0_sel_i / m1_sel_i  input  4  master byte selects.
REQ-008 SHALL have ports m0_adr_i / m1_adr_i  input  32  master address.
REQ-009 SHALL have ports m0_dat_i / m1_dat_i  input  32  master write data.
REQ-010 SHALL have ports m0_dat_o / m1_dat_o  output  32  read data to master.
REQ-011 SHALL have ports m0_ack_o / m1_ack_o  output  1  acknowledge to master.
REQ-012 SHALL have ports m0_err_o / m1_err_o  output  1  error to master (slave error or timeout).
REQ-013 SHALL have ports s_cyc_o, s_stb_o, s_we_o  output  1 each  shared-slave control.
REQ-014 SHALL have ports s_sel_o (4), s_adr_o (32), s_dat_o (32)  output  shared-slave select/address/write data.
REQ-015 SHALL have ports s_dat_i (32), s_ack_i (1), s_err_i (1)  input  shared-slave response.
REQ-016 SHALL have port grant_o  output  2  one-hot current owner (bit0=m0, bit1=m1), 00 when idle.

Function
REQ-017 SHALL implement FSM states IDLE, GRANT, ABORT.
REQ-018 IDLE: if any mN_cyc_i high, SHALL register owner and enter GRANT next cycle; no slave signals driven in the decision cycle.
REQ-019 Owner choice SHALL be round-robin: one requester wins; both requesting -> master other than last_owner wins.
REQ-020 GRANT: s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o SHALL combinationally follow the owner's inputs; non-owner sees ack/err=0.
REQ-021 GRANT: s_ack_i, s_err_i, s_dat_i SHALL route combinationally (zero latency) to owner only; non-owner mN_dat_o=0.
REQ-022 Grant SHALL be held while owner cyc stays high (multi-beat/burst); owner cyc low -> IDLE next cycle, last_owner<=owner, grant_o<=00.
REQ-023 Timeout counter SHALL clear on entering GRANT and on any cycle with s_ack_i or s_err_i; SHALL increment each GRANT cycle with owner stb high and no response.
REQ-024 Counter reaching C_TIMEOUT SHALL move to ABORT: for exactly one cycle s_cyc_o=s_stb_o=0 and owner err_o=1, then IDLE with last_owner<=owner.
REQ-025 Simultaneous s_ack_i/s_err_i and timeout SHALL resolve in favour of the slave response (no abort, counter clears).
REQ-026 Request arriving in ABORT or the GRANT->IDLE release cycle SHALL be arbitrated in the following IDLE cycle; no request lost.
REQ-027 Owner dropping cyc mid-transfer SHALL release immediately (REQ-022); late slave ack after release SHALL be discarded.

Reset
REQ-028 wb_rst_n_i low SHALL asynchronously force state=IDLE, grant_o=00, counter=0, last_owner=m1 (m0 wins first tie).
REQ-029 During reset all s_* and mN_* outputs SHALL be 0, including reset asserted mid-transaction.
REQ-030 After deassert, first arbitration SHALL occur on the first rising edge with a request.

Verification
REQ-031 m0 single write adr=0x0, dat=0xEEEEEEEE, sel=0xE, slave acks 1 cycle after stb -> s_* mirror m0, m0_ack_o=1, grant_o=01 then 00.
REQ-032 m0 and m1 request same cycle after reset, each releasing after one ack -> grants 01,10,01,10 alternating.
REQ-033 Slave never acks, C_TIMEOUT=4 -> after 4 stalled GRANT cycles one-cycle m0_err_o=1, s_cyc_o=0, then IDLE; pending m1 granted next.
REQ-034 s_ack_i in the same cycle counter hits C_TIMEOUT -> ack delivered, no err, no ABORT.
REQ-035 m1 read in progress, wb_rst_n_i pulsed low mid-cycle -> all outputs 0 immediately, grant_o=00; post-reset tie goes to m0.
REQ-036 m1 owns bus with 3-beat burst (cyc held) while m0 requests -> m0 waits until m1 cyc drops, then granted.

Source files
------------

// File: rtl/wb_arb_rr2.sv
// Two-master round-robin Wishbone arbiter in front of one shared slave.
// Combinational request/response routing, with a slave-response timeout that aborts a stalled cycle.
module wb_arb_rr2 #(
  parameter int unsigned C_TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(C_TIMEOUT);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        own_cyc, own_stb, own_we;
  logic [3:0]  own_sel;
  logic [31:0] own_adr, own_dat;

  // owner_q: 0 selects m0, 1 selects m1
  assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner_q ? m1_stb_i : m0_stb_i;
  assign own_we  = owner_q ? m1_we_i  : m0_we_i;
  assign own_sel = owner_q ? m1_sel_i : m0_sel_i;
  assign own_adr = owner_q ? m1_adr_i : m0_adr_i;
  assign own_dat = owner_q ? m1_dat_i : m0_dat_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (m0_cyc_i || m1_cyc_i) begin
          owner_d = (m0_cyc_i && m1_cyc_i) ? ~last_q : m1_cyc_i;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!own_cyc) begin
          state_d = IDLE;
          last_d  = owner_q;
          cnt_d   = 8'd0;
        end else if (s_ack_i || s_err_i) begin
          // a slave response always beats a coincident timeout
          cnt_d = 8'd0;
        end else if (own_stb) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_VAL) state_d = ABORT;
        end
      end
      ABORT: begin
        state_d = IDLE;
        last_d  = owner_q;
        cnt_d   = 8'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'd0;
    s_adr_o  = 32'd0;
    s_dat_o  = 32'd0;
    m0_dat_o = 32'd0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = 32'd0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    case (state_q)
      GRANT: begin
        grant_o = owner_q ? 2'b10 : 2'b01;
        s_cyc_o = own_cyc;
        s_stb_o = own_stb;
        s_we_o  = own_we;
        s_sel_o = own_sel;
        s_adr_o = own_adr;
        s_dat_o = own_dat;
        // responses arriving after the owner dropped cyc are swallowed
        if (owner_q) begin
          m1_dat_o = s_dat_i;
          m1_ack_o = s_ack_i & own_cyc;
          m1_err_o = s_err_i & own_cyc;
        end else begin
          m0_dat_o = s_dat_i;
          m0_ack_o = s_ack_i & own_cyc;
          m0_err_o = s_err_i & own_cyc;
        end
      end
      ABORT: begin
        grant_o  = owner_q ? 2'b10 : 2'b01;
        m0_err_o = ~owner_q;
        m1_err_o = owner_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arb_rr2.sv
// Bench for wb_arb_rr2: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level arbitration model.
module tb_wb_arb_rr2;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic        s_ack, s_err;
  logic [1:0]  grant;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_arb_rr2 #(.C_TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr),
    .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: who holds the bus, whether it is in its abort cycle, how many stalled beats so far.
  bit mdl_busy, mdl_abort;
  int mdl_own, mdl_last, mdl_stall;
  logic mdl_ocyc, mdl_ostb;
  assign mdl_ocyc = (mdl_own == 1) ? m1_cyc : m0_cyc;
  assign mdl_ostb = (mdl_own == 1) ? m1_stb : m0_stb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy <= 1'b0; mdl_abort <= 1'b0; mdl_last <= 1; mdl_stall <= 0; mdl_own <= 0;
    end else if (!mdl_busy) begin
      if (m0_cyc || m1_cyc) begin
        mdl_busy  <= 1'b1;
        mdl_stall <= 0;
        if (m0_cyc && m1_cyc) mdl_own <= 1 - mdl_last;
        else                  mdl_own <= m0_cyc ? 0 : 1;
      end
    end else if (mdl_abort) begin
      mdl_busy <= 1'b0; mdl_abort <= 1'b0; mdl_last <= mdl_own;
    end else if (!mdl_ocyc) begin
      mdl_busy <= 1'b0; mdl_last <= mdl_own;
    end else if (s_ack || s_err) begin
      mdl_stall <= 0;
    end else if (mdl_ostb) begin
      mdl_stall <= mdl_stall + 1;
      if (mdl_stall + 1 == TO) mdl_abort <= 1'b1;
    end
  end

  logic [1:0]  e_grant;
  logic        e_cyc, e_stb, e_we, e_ack0, e_err0, e_ack1, e_err1;
  logic [3:0]  e_sel;
  logic [31:0] e_adr, e_wdat, e_dat0, e_dat1;

  always @(negedge clk) begin
    e_grant = 2'b00; e_cyc = 0; e_stb = 0; e_we = 0; e_sel = 0; e_adr = 0; e_wdat = 0;
    e_ack0 = 0; e_err0 = 0; e_ack1 = 0; e_err1 = 0; e_dat0 = 0; e_dat1 = 0;
    if (rst_n && mdl_busy) begin
      e_grant = (mdl_own == 1) ? 2'b10 : 2'b01;
      if (mdl_abort) begin
        if (mdl_own == 1) e_err1 = 1; else e_err0 = 1;
      end else if (mdl_own == 1) begin
        e_cyc = m1_cyc; e_stb = m1_stb; e_we = m1_we; e_sel = m1_sel; e_adr = m1_adr; e_wdat = m1_dat;
        e_dat1 = s_rdat; e_ack1 = s_ack & m1_cyc; e_err1 = s_err & m1_cyc;
      end else begin
        e_cyc = m0_cyc; e_stb = m0_stb; e_we = m0_we; e_sel = m0_sel; e_adr = m0_adr; e_wdat = m0_dat;
        e_dat0 = s_rdat; e_ack0 = s_ack & m0_cyc; e_err0 = s_err & m0_cyc;
      end
    end
    chk("grant", {30'd0, grant}, {30'd0, e_grant});
    chk("s_ctl", {29'd0, s_cyc, s_stb, s_we}, {29'd0, e_cyc, e_stb, e_we});
    chk("s_sel", {28'd0, s_sel}, {28'd0, e_sel});
    chk("s_adr", s_adr, e_adr);
    chk("s_dat", s_wdat, e_wdat);
    chk("m_resp", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, {28'd0, e_ack0, e_err0, e_ack1, e_err1});
    chk("m0_dat", m0_rdat, e_dat0);
    chk("m1_dat", m1_rdat, e_dat1);
  end

  initial begin
    rst_n = 0;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack, s_err} = '0;
    m0_sel = 0; m1_sel = 0; m0_adr = 0; m1_adr = 0; m0_dat = 0; m1_dat = 0; s_rdat = 0;
    repeat (3) step();
    @(negedge clk);
    chk("reset grant", {30'd0, grant}, 32'd0);
    chk("reset s_cyc", {31'd0, s_cyc}, 32'd0);
    step(); rst_n = 1;

    // single m0 write, acked one cycle after strobe
    step();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hE; m0_adr = 32'h0; m0_dat = 32'hEEEEEEEE;
    @(negedge clk);
    chk("A decide grant", {30'd0, grant}, 32'd0);
    chk("A decide s_cyc", {31'd0, s_cyc}, 32'd0);
    step();
    @(negedge clk);
    chk("A grant", {30'd0, grant}, 32'd1);
    chk("A s_dat", s_wdat, 32'hEEEEEEEE);
    chk("A s_sel", {28'd0, s_sel}, 32'hE);
    chk("A s_we", {31'd0, s_we}, 32'd1);
    step(); s_ack = 1;
    @(negedge clk);
    chk("A m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("A m1_ack", {31'd0, m1_ack}, 32'd0);
    step(); s_ack = 0; m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    chk("A release grant", {30'd0, grant}, 32'd1);
    step();
    @(negedge clk);
    chk("A idle grant", {30'd0, grant}, 32'd0);

    // both masters contend after reset: strict alternation starting with m0
    step(); rst_n = 0;
    step(); rst_n = 1;
    step(); m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m0_we = 0; m1_we = 0;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      chk("B idle grant", {30'd0, grant}, 32'd0);
      step(); s_ack = 1;
      @(negedge clk);
      chk("B grant", {30'd0, grant}, (r % 2 == 0) ? 32'd1 : 32'd2);
      chk("B ack", {30'd0, m1_ack, m0_ack}, (r % 2 == 0) ? 32'd1 : 32'd2);
      step(); s_ack = 0;
      if (r % 2 == 0) begin m0_cyc = 0; m0_stb = 0; end
      else            begin m1_cyc = 0; m1_stb = 0; end
      @(negedge clk);
      step();
      if (r < 3) begin m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; end
      else       begin m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; end
    end

    // stalled slave: abort after TO stalled beats, pending m1 served next
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    @(negedge clk);
    chk("C idle grant", {30'd0, grant}, 32'd0);
    step();
    @(negedge clk);
    chk("C grant", {30'd0, grant}, 32'd1);
    repeat (3) step();
    @(negedge clk);
    chk("C last stall err", {31'd0, m0_err}, 32'd0);
    chk("C last stall cyc", {31'd0, s_cyc}, 32'd1);
    step();
    @(negedge clk);
    chk("C abort err", {31'd0, m0_err}, 32'd1);
    chk("C abort cyc/stb", {30'd0, s_cyc, s_stb}, 32'd0);
    chk("C abort grant", {30'd0, grant}, 32'd1);
    step(); m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    chk("C idle after abort", {30'd0, grant}, 32'd0);
    chk("C err cleared", {31'd0, m0_err}, 32'd0);
    step();
    @(negedge clk);
    chk("C m1 grant", {30'd0, grant}, 32'd2);
    step(); s_ack = 1;
    step(); s_ack = 0; m1_cyc = 0; m1_stb = 0;
    step();

    // ack on the very beat the counter would expire wins
    m0_cyc = 1; m0_stb = 1;
    @(negedge clk);
    step();
    repeat (3) step();
    s_ack = 1;
    @(negedge clk);
    chk("D ack", {31'd0, m0_ack}, 32'd1);
    chk("D err", {31'd0, m0_err}, 32'd0);
    step(); s_ack = 0;
    @(negedge clk);
    chk("D still granted", {30'd0, grant}, 32'd1);
    chk("D no abort", {31'd0, m0_err}, 32'd0);
    step(); m0_cyc = 0; m0_stb = 0;
    step();

    // reset mid m1 read
    m1_cyc = 1; m1_stb = 1; m1_we = 0; s_rdat = 32'hA5A55A5A;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("E m1 grant", {30'd0, grant}, 32'd2);
    chk("E m1 dat", m1_rdat, 32'hA5A55A5A);
    #1 rst_n = 0;
    #1;
    chk("E reset grant", {30'd0, grant}, 32'd0);
    chk("E reset s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("E reset m1 dat", m1_rdat, 32'd0);
    m0_cyc = 1; m0_stb = 1;
    step();
    step(); rst_n = 1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("E post-reset tie", {30'd0, grant}, 32'd1);

    // m1 burst holds the bus while m0 waits
    step(); m0_cyc = 0; m0_stb = 0;
    step();
    step(); m0_cyc = 1; m0_stb = 1; s_ack = 1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      chk("F burst grant", {30'd0, grant}, 32'd2);
      chk("F burst acks", {30'd0, m1_ack, m0_ack}, 32'd2);
      step();
    end
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    @(negedge clk);
    chk("F release grant", {30'd0, grant}, 32'd2);
    step();
    @(negedge clk);
    chk("F idle grant", {30'd0, grant}, 32'd0);
    step();
    @(negedge clk);
    chk("F m0 grant", {30'd0, grant}, 32'd1);
    step(); m0_cyc = 0; m0_stb = 0;
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rst_n = ($urandom_range(0, 399) != 0);
      if (m0_cyc) m0_cyc = ($urandom_range(0, 5) != 0); else m0_cyc = ($urandom_range(0, 2) == 0);
      if (m1_cyc) m1_cyc = ($urandom_range(0, 5) != 0); else m1_cyc = ($urandom_range(0, 2) == 0);
      m0_stb = m0_cyc & ($urandom_range(0, 3) != 0);
      m1_stb = m1_cyc & ($urandom_range(0, 3) != 0);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_sel = 4'($urandom); m1_sel = 4'($urandom);
      m0_adr = $urandom; m1_adr = $urandom; m0_dat = $urandom; m1_dat = $urandom;
      s_rdat = $urandom;
      s_ack = ($urandom_range(0, 3) == 0);
      s_err = ($urandom_range(0, 15) == 0);
    end
    step();
    rst_n = 1;
    {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err} = '0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
